// File: rtl/numlock_input_ctrl.sv
// Input front end for the numlock state machine: synchronizes and debounces
// BtnL/BtnR, emits a slow step strobe, and locks U/Z out after repeated Bad entries.
module numlock_input_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int TICK_W     = 25,
  parameter int BAD_LIMIT  = 3,
  parameter int LOCK_TICKS = 8
) (
  input  logic       ClkPort,
  input  logic       reset,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       bad_in,
  input  logic       unlock_in,
  output logic       U,
  output logic       Z,
  output logic       sm_ce,
  output logic       lockout,
  output logic [2:0] bad_cnt,
  output logic [3:0] lock_remain
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [2:0]       BAD_LAST  = 3'(BAD_LIMIT - 1);
  localparam logic [3:0]       LOCK_INIT = 4'(LOCK_TICKS);

  typedef enum logic {ST_RUN = 1'b0, ST_LOCK = 1'b1} state_t;

  logic [1:0] btn_raw;
  logic [1:0] deb_lvl;
  assign btn_raw = {BtnR, BtnL};

  // Index 0 is BtnL (U), index 1 is BtnR (Z).
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
      sync1_d = btn_raw[gi];
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge ClkPort or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end

    assign deb_lvl[gi] = deb_q;
  end

  logic [TICK_W-1:0] step_q, step_d;
  logic              tick;
  logic              u_q, u_d, z_q, z_d, sm_ce_q, sm_ce_d;
  logic              bad_prev_q, bad_prev_d, unlock_prev_q, unlock_prev_d;
  logic              bad_rise, unlock_rise;
  state_t            state_q, state_d;
  logic [2:0]        bad_cnt_q, bad_cnt_d;
  logic [3:0]        lock_remain_q, lock_remain_d;

  assign tick        = &step_q;
  assign bad_rise    = bad_in & ~bad_prev_q;
  assign unlock_rise = unlock_in & ~unlock_prev_q;

  // U/Z reload only on tick so they are stable across the sm_ce cycle that follows.
  always_comb begin
    step_d        = step_q + 1'b1;
    sm_ce_d       = tick;
    bad_prev_d    = bad_in;
    unlock_prev_d = unlock_in;
    u_d           = u_q;
    z_d           = z_q;
    if (tick) begin
      u_d = deb_lvl[0] & ~lockout;
      z_d = deb_lvl[1] & ~lockout;
    end
  end

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      step_q        <= '0;
      sm_ce_q       <= 1'b0;
      bad_prev_q    <= 1'b0;
      unlock_prev_q <= 1'b0;
      u_q           <= 1'b0;
      z_q           <= 1'b0;
      bad_cnt_q     <= '0;
      lock_remain_q <= '0;
    end else begin
      step_q        <= step_d;
      sm_ce_q       <= sm_ce_d;
      bad_prev_q    <= bad_prev_d;
      unlock_prev_q <= unlock_prev_d;
      u_q           <= u_d;
      z_q           <= z_d;
      bad_cnt_q     <= bad_cnt_d;
      lock_remain_q <= lock_remain_d;
    end
  end

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A Bad edge takes priority over a simultaneous Unlock edge.
  always_comb begin
    state_d       = state_q;
    bad_cnt_d     = bad_cnt_q;
    lock_remain_d = lock_remain_q;
    case (state_q)
      ST_RUN: begin
        if (bad_rise) begin
          if (bad_cnt_q == BAD_LAST) begin
            state_d       = ST_LOCK;
            bad_cnt_d     = '0;
            lock_remain_d = LOCK_INIT;
          end else begin
            bad_cnt_d = bad_cnt_q + 3'd1;
          end
        end else if (unlock_rise) begin
          bad_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (tick) begin
          lock_remain_d = lock_remain_q - 4'd1;
          if (lock_remain_q == 4'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    lockout = (state_q == ST_LOCK);
  end

  assign U           = u_q;
  assign Z           = z_q;
  assign sm_ce       = sm_ce_q;
  assign bad_cnt     = bad_cnt_q;
  assign lock_remain = lock_remain_q;

endmodule

// File: tb/tb_numlock_input_ctrl.sv
// Scoreboard bench for numlock_input_ctrl: a cycle-level behavioural model
// queues the expected outputs each cycle; a monitor pops and compares them.
module tb_numlock_input_ctrl;
  localparam int DEB  = 4;
  localparam int TW   = 3;
  localparam int LIM  = 3;
  localparam int LT   = 2;
  localparam int STEP = 1 << TW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       BtnL = 1'b0, BtnR = 1'b0, bad_in = 1'b0, unlock_in = 1'b0;
  logic       U, Z, sm_ce, lockout;
  logic [2:0] bad_cnt;
  logic [3:0] lock_remain;

  numlock_input_ctrl #(
    .DEB_CYCLES(DEB), .TICK_W(TW), .BAD_LIMIT(LIM), .LOCK_TICKS(LT)
  ) dut (
    .ClkPort(clk), .reset(reset), .BtnL(BtnL), .BtnR(BtnR),
    .bad_in(bad_in), .unlock_in(unlock_in), .U(U), .Z(Z), .sm_ce(sm_ce),
    .lockout(lockout), .bad_cnt(bad_cnt), .lock_remain(lock_remain)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [1:0]  m_sync1 = '0, m_sync2 = '0, m_deb = '0;
  bit          m_win0[$];
  bit          m_win1[$];
  int          m_n = 0, m_cnt = 0, m_rem = 0;
  bit          m_u = 0, m_z = 0, m_ce = 0, m_lock = 0;
  bit          m_bad_prev = 0, m_unl_prev = 0;
  bit          tk, be, ue;
  logic [10:0] exp_q[$];

  // A level is accepted once the last DEB synchronized samples all disagree with it.
  function automatic bit win_flip(bit w[$], bit d);
    if (w.size() < DEB) return 1'b0;
    foreach (w[i]) if (w[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_sync1 = '0; m_sync2 = '0; m_deb = '0;
      m_win0.delete(); m_win1.delete();
      m_n = 0; m_cnt = 0; m_rem = 0;
      m_u = 0; m_z = 0; m_ce = 0; m_lock = 0;
      m_bad_prev = 0; m_unl_prev = 0;
      exp_q.delete();
    end else begin
      tk = (m_n % STEP) == STEP - 1;
      if (tk) begin
        m_u = !m_lock && m_deb[0];
        m_z = !m_lock && m_deb[1];
      end
      m_win0.push_back(m_sync2[0]);
      if (m_win0.size() > DEB) void'(m_win0.pop_front());
      m_win1.push_back(m_sync2[1]);
      if (m_win1.size() > DEB) void'(m_win1.pop_front());
      if (win_flip(m_win0, m_deb[0])) m_deb[0] = m_sync2[0];
      if (win_flip(m_win1, m_deb[1])) m_deb[1] = m_sync2[1];
      m_sync2 = m_sync1;
      m_sync1 = {BtnR, BtnL};
      be = bad_in && !m_bad_prev;
      ue = unlock_in && !m_unl_prev;
      m_bad_prev = bad_in;
      m_unl_prev = unlock_in;
      if (m_lock) begin
        if (tk) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_lock = 0;
        end
      end else if (be) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == LIM) begin
          m_lock = 1; m_cnt = 0; m_rem = LT;
        end
      end else if (ue) begin
        m_cnt = 0;
      end
      m_ce = tk;
      m_n  = m_n + 1;
      exp_q.push_back({m_u, m_z, m_ce, m_lock, 3'(m_cnt), 4'(m_rem)});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          checks = 0, failures = 0;
  logic [10:0] act, expv;
  bit          wait_miss = 0, wait_miss_seen = 0;
  bit          final_req = 0, final_done = 0;

  initial forever begin
    @(negedge clk);
    act = {U, Z, sm_ce, lockout, bad_cnt, lock_remain};
    if (reset) begin
      checks++;
      if (act !== 11'b0) begin
        failures++;
        $display("FAIL reset_outputs t=%0t got=%b want=%b", $time, act, 11'b0);
      end
    end else if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t got U=%b Z=%b ce=%b lock=%b cnt=%0d rem=%0d want U=%b Z=%b ce=%b lock=%b cnt=%0d rem=%0d",
                 $time, act[10], act[9], act[8], act[7], act[6:4], act[3:0],
                 expv[10], expv[9], expv[8], expv[7], expv[6:4], expv[3:0]);
      end
    end
    if (wait_miss && !wait_miss_seen) begin
      wait_miss_seen = 1;
      checks++;
      failures++;
      $display("FAIL lockout_wait t=%0t got no lock_remain=1 window want one within 60 cycles", $time);
    end
    if (final_req && !final_done) begin
      final_done = 1;
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL queue_drain t=%0t got %0d pending want 0", $time, exp_q.size());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_bad();
    bad_in = 1'b1; cycles(1); bad_in = 1'b0; cycles(2);
  endtask

  task automatic pulse_unlock();
    unlock_in = 1'b1; cycles(1); unlock_in = 1'b0; cycles(2);
  endtask

  bit found;
  int len;

  initial begin
    cycles(3);
    #2 reset = 1'b0;

    // Clean BtnL press, then a short BtnR glitch that must be rejected.
    cycles(10); BtnL = 1'b1; cycles(40);
    BtnR = 1'b1; cycles(3); BtnR = 1'b0; cycles(30);

    // Lockout while BtnL is held, then recovery.
    repeat (3) pulse_bad();
    cycles(40);

    // Unlock clears the count; two more Bad edges stay below the limit.
    repeat (2) pulse_bad();
    pulse_unlock();
    repeat (2) pulse_bad();
    cycles(10);
    pulse_unlock();

    // Reset in the middle of lockout, just after a non-tick edge.
    repeat (3) pulse_bad();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_lock && m_rem == 1 && (m_n % STEP) != STEP - 1) found = 1;
    end
    if (!found) begin
      wait_miss = 1;
    end else begin
      @(posedge clk);
      #1 reset = 1'b1;
      cycles(2);
      #2 reset = 1'b0;
    end
    cycles(20);

    // Randomized buttons, glitches and Bad/Unlock activity.
    for (int seg = 0; seg < 120; seg++) begin
      BtnL = 1'($urandom_range(0, 1));
      BtnR = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        bad_in    = ($urandom_range(0, 15) == 0);
        unlock_in = ($urandom_range(0, 11) == 0);
        @(negedge clk);
      end
    end
    bad_in = 1'b0; unlock_in = 1'b0;
    cycles(20);
    final_req = 1;
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
